// File: rtl/icache_fill_ctrl_if.sv
// Request/response and backing-memory handshake bundle for icache_fill_ctrl.
// The requester and memory side use master; the cache controller uses slave.
interface icache_fill_ctrl_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        flush;

  modport master (
    output req_valid, req_addr, mem_ready, mem_data, flush,
    input  req_ready, resp_valid, resp_data, mem_rd, mem_addr
  );

  modport slave (
    input  req_valid, req_addr, mem_ready, mem_data, flush,
    output req_ready, resp_valid, resp_data, mem_rd, mem_addr
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// 64-line direct-mapped instruction cache fill controller; ICACHE_STATS_EN adds hit/miss counters.
// Hit answers 2 cycles after accept, miss 2 + memory wait; one request in flight, req_ready low while busy.
module instructionhasher (
  input  logic [31:0] addr,
  output logic [5:0]  index
);
  // Fold every address bit into the 6-bit line index.
  assign index = addr[5:0] ^ addr[11:6] ^ addr[17:12] ^ addr[23:18] ^ addr[29:24]
               ^ {4'b0000, addr[31:30]};
endmodule

module icache_fill_ctrl (
  input  logic clk,
  input  logic rst_n,
  icache_fill_ctrl_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, RESP} state_t;

  state_t      stateQ, stateD;
  logic [31:0] addrQ;
  logic [31:0] respDataQ;
  logic [63:0] validQ;
  logic [31:0] tagMem  [64];
  logic [31:0] dataMem [64];
  logic [5:0]  lineIdx;
  logic        flushPendQ;
  logic        runQ;
  logic        reqReady;
  logic        accept;
  logic        hit;
  logic        fillEn;
  logic        flushNow;

  instructionhasher uHash (.addr(addrQ), .index(lineIdx));

  // runQ keeps req_ready low until the first clock edge after reset release.
  assign reqReady = runQ && (stateQ == IDLE) && !bus.flush;
  assign accept   = bus.req_valid && reqReady;
  assign hit      = validQ[lineIdx] && (tagMem[lineIdx] == addrQ);
  assign fillEn   = (stateQ == MISS) && bus.mem_ready;
  assign flushNow = ((stateQ == IDLE) && bus.flush)
                  || ((stateQ == RESP) && (flushPendQ || bus.flush));

  assign bus.req_ready = reqReady;
  assign bus.resp_data = respDataQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD         = stateQ;
    bus.resp_valid = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_addr   = '0;
    case (stateQ)
      IDLE:   if (accept) stateD = LOOKUP;
      LOOKUP: stateD = hit ? RESP : MISS;
      MISS: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = addrQ;
        if (bus.mem_ready) stateD = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        stateD         = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runQ       <= 1'b0;
      addrQ      <= '0;
      respDataQ  <= '0;
      validQ     <= '0;
      flushPendQ <= 1'b0;
    end else begin
      runQ <= 1'b1;
      if (accept) addrQ <= bus.req_addr;
      if ((stateQ == LOOKUP) && hit) respDataQ <= dataMem[lineIdx];
      if (fillEn) respDataQ <= bus.mem_data;
      // A flush seen mid-transaction waits until the response has gone out.
      if (stateQ == RESP)                    flushPendQ <= 1'b0;
      else if ((stateQ != IDLE) && bus.flush) flushPendQ <= 1'b1;
      if (flushNow)    validQ          <= '0;
      else if (fillEn) validQ[lineIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fillEn) begin
      tagMem[lineIdx]  <= addrQ;
      dataMem[lineIdx] <= bus.mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (stateQ == LOOKUP) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl with an address-level cache model and per-cycle output compare.
module tb_icache_fill_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  icache_fill_ctrl_if bus();
`ifdef ICACHE_STATS_EN
  logic [15:0] hitCount, missCount;
`endif

  icache_fill_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hitCount),
    .miss_count(missCount)
`endif
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
    int          acc;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        mValid [64];
  logic [31:0] mTag   [64];
  logic [31:0] mData  [64];
  bit          mFlushPend = 0;
  int          mHits = 0;
  int          mMisses = 0;

  exp_t        expQ[$];
  logic [31:0] missQ[$];
  int          memWait = 1;
  int          waitCnt = 0;
  bit          inReset = 1;
  bit          spurious = 0;
  int          lastLat = 0;
  logic [31:0] lastData = '0;

  localparam logic [31:0] TRACE [0:13] = '{
    32'h0000_0100, 32'h0000_0104, 32'h0000_0100, 32'h0000_0040, 32'h0000_1000,
    32'h0000_0040, 32'h0000_0104, 32'h0000_1100, 32'h0000_0100, 32'h0000_1000,
    32'h0000_1000, 32'h0000_2040, 32'h0000_0040, 32'h0000_0104};

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line index: XOR of the address split into 6-bit groups from the LSB.
  function automatic int hashOf(input logic [31:0] a);
    int idx = 0;
    logic [31:0] w = a;
    for (int k = 0; k < 6; k++) begin
      idx = idx ^ int'(w[5:0]);
      w = w >> 6;
    end
    return idx;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
  endfunction

  // Per-cycle compare against the model, plus the backing-memory responder.
  always @(negedge clk) begin
    if (!inReset) begin
      check32("req_ready", bus.req_ready, (expQ.size() == 0) && !bus.flush);
      if (expQ.size() > 0 && cyc == expQ[0].cyc) begin
        check32("resp_valid", bus.resp_valid, 1'b1);
        check32("resp_data", bus.resp_data, expQ[0].data);
        lastData = bus.resp_data;
        lastLat  = cyc - expQ[0].acc;
        void'(expQ.pop_front());
      end else if (bus.resp_valid) begin
        check32("spurious resp_valid", bus.resp_valid, 1'b0);
      end
      if (bus.mem_rd) begin
        if (missQ.size() == 0) check32("unexpected mem_rd", bus.mem_rd, 1'b0);
        else                   check32("mem_addr", bus.mem_addr, missQ[0]);
      end
    end
    if (bus.mem_rd) begin
      waitCnt++;
      if (waitCnt >= memWait) begin
        bus.mem_ready = 1'b1;
        bus.mem_data  = memWord(bus.mem_addr);
        if (missQ.size() > 0) void'(missQ.pop_front());
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_data  = '0;
      end
    end else begin
      waitCnt       = 0;
      bus.mem_ready = spurious;
      bus.mem_data  = spurious ? 32'hBAD0_BAD0 : 32'h0;
    end
  end

  task automatic issue(input logic [31:0] a, input int w);
    int n = 0;
    int acc;
    int h;
    bit isHit;
    exp_t e;
    memWait = w;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check32("accept timeout", bus.req_ready, 1'b1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    acc = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    h = hashOf(a);
    isHit = mValid[h] && (mTag[h] == a);
    e.acc  = acc;
    e.data = isHit ? mData[h] : memWord(a);
    e.cyc  = acc + 2 + (isHit ? 0 : w);
    if (isHit) mHits++;
    else begin
      mMisses++;
      missQ.push_back(a);
      mValid[h] = 1'b1;
      mTag[h]   = a;
      mData[h]  = e.data;
    end
    expQ.push_back(e);
  endtask

  task automatic waitDone();
    int n = 0;
    while (expQ.size() > 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (expQ.size() > 0) begin
      check32("response timeout", expQ.size(), 0);
      expQ.delete();
      missQ.delete();
    end
    if (mFlushPend) begin
      modelClear();
      mFlushPend = 0;
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int w);
    issue(a, w);
    waitDone();
  endtask

  task automatic doReset();
    inReset = 1;
    rst_n = 1'b0;
    #1;
    check32("reset mem_rd", bus.mem_rd, 1'b0);
    check32("reset req_ready", bus.req_ready, 1'b0);
    check32("reset resp_valid", bus.resp_valid, 1'b0);
    check32("reset mem_addr", bus.mem_addr, 32'h0);
    check32("reset resp_data", bus.resp_data, 32'h0);
    modelClear();
    expQ.delete();
    missQ.delete();
    mFlushPend = 0;
    mHits = 0;
    mMisses = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    inReset = 0;
  endtask

  task automatic checkStats(input int h, input int m);
`ifdef ICACHE_STATS_EN
    check32("hit_count", {16'h0, hitCount}, h);
    check32("miss_count", {16'h0, missCount}, m);
`endif
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    modelClear();
    #2;
    doReset();
    checkStats(0, 0);

    // Cold miss, then the same address hits.
    fetch(32'h0000_1000, 3);
    check32("cold data", lastData, 32'hDEAD_BEEF);
    check32("cold latency", lastLat, 5);
    fetch(32'h0000_1000, 3);
    check32("hit data", lastData, 32'hDEAD_BEEF);
    check32("hit latency", lastLat, 2);
    checkStats(1, 1);

    // 0x40 shares the line of 0x1000: each evicts the other.
    fetch(32'h0000_0040, 2);
    check32("collide latency", lastLat, 4);
    fetch(32'h0000_1000, 3);
    check32("evicted refetch latency", lastLat, 5);
    fetch(32'h0000_0040, 2);

    // Stray mem_ready while idle must not disturb anything.
    spurious = 1;
    repeat (3) @(posedge clk);
    #1;
    spurious = 0;
    fetch(32'h0000_0040, 1);
    check32("hit after stray mem_ready", lastLat, 2);

    // Flush while idle.
    @(posedge clk); #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    modelClear();
    fetch(32'h0000_0040, 2);
    check32("miss after idle flush", lastLat, 4);

    // Flush during a pending miss: fill completes, then the line is gone.
    fork
      fetch(32'h0000_2000, 6);
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        mFlushPend = 1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
      end
    join
    check32("fill under flush data", lastData, memWord(32'h0000_2000));
    fetch(32'h0000_2000, 2);
    check32("miss after pending flush", lastLat, 4);

    // Flush and request together: request must be refused.
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h0000_3000;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    modelClear();
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of a miss.
    issue(32'h0000_0500, 30);
    for (int n = 0; n < 10 && !bus.mem_rd; n++) begin
      @(posedge clk);
      #1;
    end
    check32("mem_rd before reset", bus.mem_rd, 1'b1);
    doReset();
    checkStats(0, 0);
    fetch(32'h0000_0500, 2);
    check32("miss after reset", lastLat, 4);

    // Address trace replay, back-to-back.
    for (int i = 0; i < 14; i++) fetch(TRACE[i], (i % 4) + 1);
    checkStats(mHits, mMisses);

    check32("leftover responses", expQ.size(), 0);
    check32("leftover misses", missQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
